// File: rtl/trigger_seq.sv
// trigger_seq: multi-stage sequential trigger for the logic-capture path.
//
// A sequence of up to STAGES stages is armed and walked in order. Each stage
// selects channels with a mask and checks each selected channel for a level
// or an edge. A stage must score cfg_count+1 hits to advance. An optional
// per-stage timeout restarts the sequence at stage 0. An empty stage (mask 0)
// or a hit on the last stage completes the sequence.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   cfg_wr/cfg_stage    stage register write strobe and index (idle only)
//   cfg_mask/type/level stage channel enable, match type {b1,b0}, level
//   cfg_count           hits needed minus one
//   cfg_timeout         per-stage cycle budget, 0 = off, latched on arm
//   dinput              sampled channels
//   arm/abort/ignore    start, cancel, sample-invalid
//   armed/triggered     sequence running / sequence complete (sticky)
//   trig_pulse          one-cycle strobe when triggered rises
//   stage/hit_count     current stage and hits scored in it
module trigger_seq #(
    parameter int unsigned DSIZE  = 32,
    parameter int unsigned STAGES = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TMO_W  = 24,
    parameter int unsigned SW     = $clog2(STAGES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_wr,
    input  logic [SW-1:0]        cfg_stage,
    input  logic [DSIZE-1:0]     cfg_mask,
    input  logic [2*DSIZE-1:0]   cfg_type,
    input  logic [DSIZE-1:0]     cfg_level,
    input  logic [CNT_W-1:0]     cfg_count,
    input  logic [TMO_W-1:0]     cfg_timeout,
    input  logic [DSIZE-1:0]     dinput,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 ignore,
    output logic                 armed,
    output logic                 triggered,
    output logic                 trig_pulse,
    output logic [SW-1:0]        stage,
    output logic [CNT_W-1:0]     hit_count
);

    localparam logic [SW:0]   NumStages = STAGES[SW:0];
    localparam int unsigned   LastIdx   = STAGES - 1;
    localparam logic [SW-1:0] LastStage = LastIdx[SW-1:0];

    typedef enum logic {
        StIdle,
        StArmed
    } state_e;

    state_e state_q, state_d;

    logic [DSIZE-1:0]   mask_q  [STAGES];
    logic [DSIZE-1:0]   mask_d  [STAGES];
    logic [2*DSIZE-1:0] type_q  [STAGES];
    logic [2*DSIZE-1:0] type_d  [STAGES];
    logic [DSIZE-1:0]   level_q [STAGES];
    logic [DSIZE-1:0]   level_d [STAGES];
    logic [CNT_W-1:0]   count_q [STAGES];
    logic [CNT_W-1:0]   count_d [STAGES];

    logic [DSIZE-1:0] prev_q, prev_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             triggered_q, triggered_d;
    logic             pulse_q, pulse_d;

    logic [DSIZE-1:0]   cur_mask;
    logic [2*DSIZE-1:0] cur_type;
    logic [DSIZE-1:0]   cur_level;
    logic [CNT_W-1:0]   cur_count;
    logic [DSIZE-1:0]   chan_match;
    logic               stage_hit;
    logic               tmo_expired;

    assign cur_mask  = mask_q[stage_q];
    assign cur_type  = type_q[stage_q];
    assign cur_level = level_q[stage_q];
    assign cur_count = count_q[stage_q];

    // Per-channel match against the current stage's type selection.
    always_comb begin
        chan_match = '0;
        for (int i = 0; i < int'(DSIZE); i++) begin
            case (cur_type[2*i +: 2])
                2'b00:   chan_match[i] = (dinput[i] == cur_level[i]);
                2'b01:   chan_match[i] = ~prev_q[i] & dinput[i];
                2'b10:   chan_match[i] = prev_q[i] & ~dinput[i];
                default: chan_match[i] = prev_q[i] ^ dinput[i];
            endcase
        end
    end

    // Unmasked channels are forced true so only masked ones can veto the hit.
    assign stage_hit = (state_q == StArmed) & ~ignore & (|cur_mask) &
                       (&(chan_match | ~cur_mask));

    // Timeout is evaluated only on valid samples, matching the frozen timer.
    assign tmo_expired = (tmo_q != '0) & (stage_q != '0) & ~ignore &
                         (timer_q == tmo_q - TMO_W'(1));

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        type_d      = type_q;
        level_d     = level_q;
        count_d     = count_q;
        prev_d      = ignore ? prev_q : dinput;
        stage_d     = stage_q;
        hit_cnt_d   = hit_cnt_q;
        timer_d     = timer_q;
        tmo_d       = tmo_q;
        triggered_d = triggered_q;
        pulse_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (cfg_wr && ({1'b0, cfg_stage} < NumStages)) begin
                    mask_d[cfg_stage]  = cfg_mask;
                    type_d[cfg_stage]  = cfg_type;
                    level_d[cfg_stage] = cfg_level;
                    count_d[cfg_stage] = cfg_count;
                end
                if (arm) begin
                    state_d     = StArmed;
                    stage_d     = '0;
                    hit_cnt_d   = '0;
                    timer_d     = '0;
                    triggered_d = 1'b0;
                    tmo_d       = cfg_timeout;
                end
            end

            StArmed: begin
                if (abort) begin
                    state_d   = StIdle;
                    stage_d   = '0;
                    hit_cnt_d = '0;
                    timer_d   = '0;
                end else if (cur_mask == '0) begin
                    // Empty stage marks the end of a shorter sequence.
                    state_d     = StIdle;
                    stage_d     = '0;
                    hit_cnt_d   = '0;
                    timer_d     = '0;
                    triggered_d = 1'b1;
                    pulse_d     = 1'b1;
                end else if (stage_hit) begin
                    if (hit_cnt_q == cur_count) begin
                        if (stage_q == LastStage) begin
                            state_d     = StIdle;
                            stage_d     = '0;
                            hit_cnt_d   = '0;
                            timer_d     = '0;
                            triggered_d = 1'b1;
                            pulse_d     = 1'b1;
                        end else begin
                            stage_d   = stage_q + SW'(1);
                            hit_cnt_d = '0;
                            timer_d   = '0;
                        end
                    end else begin
                        // Non-final hit: timer deliberately left untouched.
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                end else if (tmo_expired) begin
                    stage_d   = '0;
                    hit_cnt_d = '0;
                    timer_d   = '0;
                end else if ((stage_q != '0) && !ignore && (tmo_q != '0)) begin
                    timer_d = timer_q + TMO_W'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            stage_q     <= '0;
            hit_cnt_q   <= '0;
            timer_q     <= '0;
            tmo_q       <= '0;
            triggered_q <= 1'b0;
            pulse_q     <= 1'b0;
            for (int s = 0; s < int'(STAGES); s++) begin
                mask_q[s]  <= '0;
                type_q[s]  <= '0;
                level_q[s] <= '0;
                count_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            stage_q     <= stage_d;
            hit_cnt_q   <= hit_cnt_d;
            timer_q     <= timer_d;
            tmo_q       <= tmo_d;
            triggered_q <= triggered_d;
            pulse_q     <= pulse_d;
            mask_q      <= mask_d;
            type_q      <= type_d;
            level_q     <= level_d;
            count_q     <= count_d;
        end
    end

    assign armed      = (state_q == StArmed);
    assign triggered  = triggered_q;
    assign trig_pulse = pulse_q;
    assign stage      = stage_q;
    assign hit_count  = hit_cnt_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Testbench for trigger_seq: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the trigger sequencer.
module tb_trigger_seq;

    localparam int DSIZE  = 32;
    localparam int STAGES = 8;
    localparam int CNT_W  = 16;
    localparam int TMO_W  = 24;
    localparam int SW     = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_wr;
    logic [SW-1:0]      cfg_stage;
    logic [DSIZE-1:0]   cfg_mask;
    logic [2*DSIZE-1:0] cfg_type;
    logic [DSIZE-1:0]   cfg_level;
    logic [CNT_W-1:0]   cfg_count;
    logic [TMO_W-1:0]   cfg_timeout;
    logic [DSIZE-1:0]   dinput;
    logic               arm;
    logic               abort;
    logic               ignore;
    logic               armed;
    logic               triggered;
    logic               trig_pulse;
    logic [SW-1:0]      stage;
    logic [CNT_W-1:0]   hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    // {armed, triggered, trig_pulse, stage}
    wire [5:0] status = {armed, triggered, trig_pulse, stage};

    trigger_seq #(
        .DSIZE (DSIZE),
        .STAGES(STAGES),
        .CNT_W (CNT_W),
        .TMO_W (TMO_W),
        .SW    (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_wr     (cfg_wr),
        .cfg_stage  (cfg_stage),
        .cfg_mask   (cfg_mask),
        .cfg_type   (cfg_type),
        .cfg_level  (cfg_level),
        .cfg_count  (cfg_count),
        .cfg_timeout(cfg_timeout),
        .dinput     (dinput),
        .arm        (arm),
        .abort      (abort),
        .ignore     (ignore),
        .armed      (armed),
        .triggered  (triggered),
        .trig_pulse (trig_pulse),
        .stage      (stage),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_armed, m_trig, m_pulse;
    int          m_stage, m_hits, m_timer, m_tmo;
    logic [31:0] m_mask  [STAGES];
    logic [63:0] m_type  [STAGES];
    logic [31:0] m_level [STAGES];
    int          m_count [STAGES];
    logic [31:0] m_prev;

    function automatic bit chan_ok(logic [1:0] t, logic p, logic d, logic l);
        case (t)
            2'd0:    return d == l;
            2'd1:    return !p && d;
            2'd2:    return p && !d;
            default: return p != d;
        endcase
    endfunction

    task automatic model_reset();
        m_armed = 0; m_trig = 0; m_pulse = 0;
        m_stage = 0; m_hits = 0; m_timer = 0; m_tmo = 0; m_prev = '0;
        for (int s = 0; s < STAGES; s++) begin
            m_mask[s] = '0; m_type[s] = '0; m_level[s] = '0; m_count[s] = 0;
        end
    endtask

    task automatic model_finish(bit fired);
        m_armed = 0; m_stage = 0; m_hits = 0; m_timer = 0;
        if (fired) begin
            m_trig = 1; m_pulse = 1;
        end
    endtask

    // Evaluates the sequencer rules for the coming clock edge.
    task automatic model_edge();
        bit hit;
        hit = 0;
        if (m_armed && !ignore && m_mask[m_stage] != 0) begin
            hit = 1;
            for (int i = 0; i < DSIZE; i++)
                if (m_mask[m_stage][i] &&
                    !chan_ok(m_type[m_stage][2*i +: 2], m_prev[i], dinput[i],
                             m_level[m_stage][i]))
                    hit = 0;
        end
        m_pulse = 0;
        if (!m_armed) begin
            if (cfg_wr && int'(cfg_stage) < STAGES) begin
                m_mask[cfg_stage]  = cfg_mask;
                m_type[cfg_stage]  = cfg_type;
                m_level[cfg_stage] = cfg_level;
                m_count[cfg_stage] = int'(cfg_count);
            end
            if (arm) begin
                m_armed = 1; m_stage = 0; m_hits = 0; m_timer = 0; m_trig = 0;
                m_tmo = int'(cfg_timeout);
            end
        end else if (abort) begin
            model_finish(0);
        end else if (m_mask[m_stage] == 0) begin
            model_finish(1);
        end else if (hit) begin
            if (m_hits == m_count[m_stage]) begin
                if (m_stage == STAGES - 1) model_finish(1);
                else begin
                    m_stage++; m_hits = 0; m_timer = 0;
                end
            end else m_hits++;
        end else if (m_tmo != 0 && m_stage > 0 && !ignore && m_timer == m_tmo - 1) begin
            m_stage = 0; m_hits = 0; m_timer = 0;
        end else if (m_stage > 0 && !ignore) begin
            m_timer++;
        end
        if (!ignore) m_prev = dinput;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        cfg_wr = 0; cfg_stage = '0; cfg_mask = '0; cfg_type = '0; cfg_level = '0;
        cfg_count = '0; cfg_timeout = '0; dinput = '0; arm = 0; abort = 0; ignore = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic write_stage(int idx, logic [31:0] msk, logic [63:0] typ,
                               logic [31:0] lvl, int cnt);
        cfg_stage = 3'(idx); cfg_mask = msk; cfg_type = typ; cfg_level = lvl;
        cfg_count = 16'(cnt); cfg_wr = 1;
        tick();
        cfg_wr = 0;
    endtask

    task automatic clear_cfg();
        for (int s = 0; s < STAGES; s++) write_stage(s, '0, '0, '0, 0);
    endtask

    task automatic do_arm();
        arm = 1;
        tick();
        arm = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        quiet_inputs();
        do_reset();
        n_checks++;
        if (status !== 6'b000000 || hit_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %b/%0d exp 000000/0", status, hit_count);
        end
        do_arm();
        n_checks++;
        if (status !== 6'b100000) begin
            n_fail++; $display("FAIL t1_armed got %b exp 100000", status);
        end
        tick();
        n_checks++;
        if (status !== 6'b011000) begin
            n_fail++; $display("FAIL t1_trigger got %b exp 011000", status);
        end
        tick();
        n_checks++;
        if (status !== 6'b010000) begin
            n_fail++; $display("FAIL t1_pulse_once got %b exp 010000", status);
        end
    endtask

    task automatic test_level_rise();
        clear_cfg();
        write_stage(0, 32'h1, 64'h0, 32'h1, 0);
        write_stage(1, 32'h2, 64'h4, 32'h0, 0);
        dinput = 32'h0;
        do_arm();
        dinput = 32'h1;
        tick();
        n_checks++;
        if (status !== 6'b100001) begin
            n_fail++; $display("FAIL t2_stage1 got %b exp 100001", status);
        end
        dinput = 32'h3;
        tick();
        n_checks++;
        if (status !== 6'b100010) begin
            n_fail++; $display("FAIL t2_stage2 got %b exp 100010", status);
        end
        tick();
        n_checks++;
        if (status !== 6'b011000) begin
            n_fail++; $display("FAIL t2_trigger got %b exp 011000", status);
        end
        dinput = '0;
    endtask

    task automatic test_count();
        clear_cfg();
        write_stage(0, 32'h4, 64'h10, 32'h0, 2);
        dinput = '0;
        do_arm();
        dinput = 32'h4; tick();
        n_checks++;
        if (hit_count !== 16'd1 || status !== 6'b100000) begin
            n_fail++; $display("FAIL t3_hit1 got %0d/%b exp 1/100000", hit_count, status);
        end
        dinput = 0; tick(); tick();
        dinput = 32'h4; tick();
        n_checks++;
        if (hit_count !== 16'd2 || status !== 6'b100000) begin
            n_fail++; $display("FAIL t3_hit2 got %0d/%b exp 2/100000", hit_count, status);
        end
        dinput = 0; tick();
        dinput = 32'h4; tick();
        n_checks++;
        if (hit_count !== 16'd0 || status !== 6'b100001) begin
            n_fail++; $display("FAIL t3_advance got %0d/%b exp 0/100001", hit_count, status);
        end
        tick();
        n_checks++;
        if (status !== 6'b011000) begin
            n_fail++; $display("FAIL t3_trigger got %b exp 011000", status);
        end
        dinput = '0;
    endtask

    task automatic test_timeout();
        clear_cfg();
        write_stage(0, 32'h1, 64'h0, 32'h1, 0);
        write_stage(1, 32'h2, 64'h0, 32'h2, 0);
        dinput = '0; cfg_timeout = 24'd5;
        do_arm();
        cfg_timeout = '0;
        dinput = 32'h1; tick();
        dinput = 32'h0;
        repeat (4) tick();
        n_checks++;
        if (status !== 6'b100001) begin
            n_fail++; $display("FAIL t4_before_tmo got %b exp 100001", status);
        end
        tick();
        n_checks++;
        if (status !== 6'b100000) begin
            n_fail++; $display("FAIL t4_tmo got %b exp 100000", status);
        end
        dinput = 32'h1; tick();
        dinput = 32'h0;
        repeat (2) tick();
        ignore = 1; repeat (3) tick();
        ignore = 0; repeat (2) tick();
        n_checks++;
        if (status !== 6'b100001) begin
            n_fail++; $display("FAIL t4_ign_before_tmo got %b exp 100001", status);
        end
        tick();
        n_checks++;
        if (status !== 6'b100000) begin
            n_fail++; $display("FAIL t4_ign_tmo got %b exp 100000", status);
        end
        abort = 1; tick(); abort = 0;
        n_checks++;
        if (status !== 6'b000000) begin
            n_fail++; $display("FAIL t4_abort got %b exp 000000", status);
        end
    endtask

    task automatic test_abort_and_locked_cfg();
        for (int s = 0; s < STAGES; s++) write_stage(s, 32'h1, 64'h0, 32'h1, 0);
        dinput = '0;
        do_arm();
        dinput = 32'h1;
        repeat (7) tick();
        n_checks++;
        if (status !== 6'b100111) begin
            n_fail++; $display("FAIL t5_last_stage got %b exp 100111", status);
        end
        abort = 1; tick(); abort = 0;
        n_checks++;
        if (status !== 6'b000000) begin
            n_fail++; $display("FAIL t5_abort_wins got %b exp 000000", status);
        end
        dinput = '0;
        do_arm();
        cfg_stage = 3'd0; cfg_mask = '0; cfg_type = '0; cfg_level = '0; cfg_count = '0;
        cfg_wr = 1; tick(); cfg_wr = 0;
        tick();
        n_checks++;
        if (status !== 6'b100000) begin
            n_fail++; $display("FAIL t5_cfg_locked got %b exp 100000", status);
        end
        abort = 1; tick(); abort = 0;
        do_arm();
        dinput = 32'h1;
        repeat (7) tick();
        n_checks++;
        if (status !== 6'b100111) begin
            n_fail++; $display("FAIL t5_rerun_stage got %b exp 100111", status);
        end
        tick();
        n_checks++;
        if (status !== 6'b011000) begin
            n_fail++; $display("FAIL t5_rerun_trigger got %b exp 011000", status);
        end
        dinput = '0;
    endtask

    task automatic test_any_edge_chain();
        for (int s = 0; s < STAGES; s++) write_stage(s, 32'h1, 64'h3, 32'h0, 0);
        dinput = '0;
        do_arm();
        repeat (7) begin
            dinput = ~dinput & 32'h1;
            tick();
        end
        n_checks++;
        if (status !== 6'b100111) begin
            n_fail++; $display("FAIL t6_seven_toggles got %b exp 100111", status);
        end
        dinput = ~dinput & 32'h1;
        tick();
        n_checks++;
        if (status !== 6'b011000) begin
            n_fail++; $display("FAIL t6_trigger got %b exp 011000", status);
        end
        dinput = '0;
    endtask

    task automatic test_mid_reset();
        clear_cfg();
        write_stage(0, 32'h1, 64'h0, 32'h1, 0);
        write_stage(1, 32'h2, 64'h0, 32'h2, 0);
        dinput = '0;
        do_arm();
        dinput = 32'h1; tick();
        do_reset();
        n_checks++;
        if (status !== 6'b000000) begin
            n_fail++; $display("FAIL mid_reset got %b exp 000000", status);
        end
        dinput = '0;
        do_arm();
        tick();
        n_checks++;
        if (status !== 6'b011000) begin
            n_fail++; $display("FAIL mid_reset_cfg_cleared got %b exp 011000", status);
        end
    endtask

    task automatic test_random();
        logic [31:0] msk;
        int r;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0) msk = '0;
            else if (r < 6) msk = 32'h1 << $urandom_range(0, 3);
            else msk = 32'($urandom_range(1, 15));
            cfg_wr      = ($urandom_range(0, 3) == 0);
            cfg_stage   = 3'($urandom);
            cfg_mask    = msk;
            cfg_type    = {$urandom, $urandom};
            cfg_level   = $urandom;
            cfg_count   = 16'($urandom_range(0, 2));
            cfg_timeout = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(2, 12)) : 24'd0;
            arm         = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 40) == 0);
            ignore      = ($urandom_range(0, 9) == 0);
            dinput      = $urandom;
            tick();
            n_checks++;
            if (armed !== m_armed || triggered !== m_trig || trig_pulse !== m_pulse ||
                int'(stage) !== m_stage || int'(hit_count) !== m_hits) begin
                n_fail++;
                $display("FAIL rand_cycle %0d got a%b t%b p%b s%0d h%0d exp a%b t%b p%b s%0d h%0d",
                         c, armed, triggered, trig_pulse, stage, hit_count,
                         m_armed, m_trig, m_pulse, m_stage, m_hits);
            end
        end
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_level_rise();
        test_count();
        test_timeout();
        test_abort_and_locked_cfg();
        test_any_edge_chain();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
